ecpri_tx: RTL and testbench

Byte-serial eCPRI response transmitter, the transmit end of the eCPRI remote-memory path. Accepts one-cycle `send_write_resp` / `send_read_resp` requests from the eCPRI receiver and builds a complete Ethernet/IP/UDP/eCPRI response frame. The 42-byte L2–L4 header and any read-response payload are fetched from packet memory through a single read port. Frames stream out on a valid/ready byte interface toward the MAC FIFO.

---
 rtl/ecpri_tx.sv | 201 ++++++++++++++++++++
 tb/tb_ecpri_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ecpri_tx.sv
// ecpri_tx: builds Ethernet/IP/UDP/eCPRI write- and read-response frames byte-serially on a valid/ready stream.
// Optional ECPRI_TX_PAD_EN: zero-pad frames shorter than 60 bytes up to exactly 60 bytes.
module ecpri_tx #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] HDR_BASE   = '0,
    parameter int                    HDR_LEN    = 42
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_write_resp,
    input  logic                  send_read_resp,
    input  logic [7:0]            resp_payload_len,
    input  logic [ADDR_WIDTH-1:0] resp_src_addr,
    output logic [ADDR_WIDTH-1:0] addr_3,
    output logic                  oe_3,
    input  logic [DATA_WIDTH-1:0] data_3,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic                  busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ECPRI,
        S_RID,
        S_PAYLOAD
`ifdef ECPRI_TX_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t                r_state, w_state_next;
    logic                  r_present, w_present_next;
    logic                  r_fresh;
    logic [15:0]           r_cnt, w_cnt_next;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_is_read;
    logic [7:0]            r_len;
    logic [ADDR_WIDTH-1:0] r_src;
    logic                  r_pend_wr, r_pend_rd;
    logic [7:0]            r_pend_len;
    logic [ADDR_WIDTH-1:0] r_pend_src;

    logic                  w_rd_any, w_wr_any, w_start;
    logic                  w_has_payload, w_data_last, w_last, w_from_mem;
    logic [7:0]            w_len_sel;
    logic [ADDR_WIDTH-1:0] w_src_sel, w_addr;
    logic [15:0]           w_size;
    logic [DATA_WIDTH-1:0] w_const, w_byte;

    // Incoming pulses count as pending so a request can start a frame on the very edge it arrives.
    assign w_rd_any      = r_pend_rd | send_read_resp;
    assign w_wr_any      = r_pend_wr | send_write_resp;
    assign w_len_sel     = send_read_resp ? resp_payload_len : r_pend_len;
    assign w_src_sel     = send_read_resp ? resp_src_addr : r_pend_src;
    assign w_has_payload = r_is_read && (r_len != 8'd0);
    assign w_size        = r_is_read ? (16'(r_len) + 16'd1) : 16'd1;
    assign w_data_last   = ((r_state == S_RID) && !w_has_payload) ||
                           ((r_state == S_PAYLOAD) && (r_cnt == 16'(r_len) - 16'd1));

`ifdef ECPRI_TX_PAD_EN
    localparam int MIN_FRAME = 60;
    logic [15:0] w_frame_len, w_pad_len;
    assign w_frame_len = 16'(HDR_LEN + 5) + (r_is_read ? 16'(r_len) : 16'd0);
    assign w_pad_len   = (w_frame_len < 16'(MIN_FRAME)) ? 16'(MIN_FRAME) - w_frame_len : 16'd0;
    assign w_last      = (w_data_last && (w_pad_len == 16'd0)) ||
                         ((r_state == S_PAD) && (r_cnt == w_pad_len - 16'd1));
`else
    assign w_last      = w_data_last;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_present_next = r_present;
        w_cnt_next     = r_cnt;
        w_start        = 1'b0;
        if (r_state == S_IDLE) begin
            w_start = w_rd_any | w_wr_any;
        end else if (!r_present) begin
            w_present_next = 1'b1;
        end else if (tx_ready) begin
            w_present_next = 1'b0;
            w_cnt_next     = r_cnt + 16'd1;
            if (w_last) begin
                w_state_next = S_IDLE;
                w_start      = w_rd_any | w_wr_any;
            end else begin
                case (r_state)
                    S_HDR: begin
                        if (r_cnt == 16'(HDR_LEN - 1)) begin
                            w_state_next = S_ECPRI;
                            w_cnt_next   = '0;
                        end
                    end
                    S_ECPRI: begin
                        if (r_cnt == 16'd3) begin
                            w_state_next = S_RID;
                            w_cnt_next   = '0;
                        end
                    end
                    S_RID: begin
                        w_cnt_next = '0;
`ifdef ECPRI_TX_PAD_EN
                        w_state_next = w_has_payload ? S_PAYLOAD : S_PAD;
`else
                        w_state_next = S_PAYLOAD;
`endif
                    end
`ifdef ECPRI_TX_PAD_EN
                    S_PAYLOAD: begin
                        if (w_data_last) begin
                            w_state_next = S_PAD;
                            w_cnt_next   = '0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
        if (w_start) begin
            w_state_next   = S_HDR;
            w_present_next = 1'b0;
            w_cnt_next     = '0;
        end
    end

    // Memory bytes come straight from data_3 on their first present cycle, then from r_hold while stalled.
    always_comb begin
        w_from_mem = (r_state == S_HDR) || (r_state == S_PAYLOAD);
        w_const    = '0;
        if (r_state == S_ECPRI) begin
            case (r_cnt[1:0])
                2'd0:    w_const = DATA_WIDTH'(8'h10);
                2'd1:    w_const = r_is_read ? DATA_WIDTH'(8'h01) : DATA_WIDTH'(8'h11);
                2'd2:    w_const = DATA_WIDTH'(w_size[15:8]);
                default: w_const = DATA_WIDTH'(w_size[7:0]);
            endcase
        end
        w_addr = (r_state == S_PAYLOAD) ? (r_src + ADDR_WIDTH'(r_cnt))
                                        : (HDR_BASE + ADDR_WIDTH'(r_cnt));
        w_byte = w_from_mem ? (r_fresh ? data_3 : r_hold) : w_const;
    end

    assign oe_3     = !r_present && w_from_mem;
    assign addr_3   = oe_3 ? w_addr : '0;
    assign tx_valid = r_present;
    assign tx_data  = r_present ? w_byte : '0;
    assign tx_sop   = r_present && (r_state == S_HDR) && (r_cnt == 16'd0);
    assign tx_eop   = r_present && w_last;
    assign busy     = (r_state != S_IDLE) || r_pend_wr || r_pend_rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_present  <= 1'b0;
            r_fresh    <= 1'b0;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_is_read  <= 1'b0;
            r_len      <= '0;
            r_src      <= '0;
            r_pend_wr  <= 1'b0;
            r_pend_rd  <= 1'b0;
            r_pend_len <= '0;
            r_pend_src <= '0;
        end else begin
            r_state   <= w_state_next;
            r_present <= w_present_next;
            r_cnt     <= w_cnt_next;
            r_fresh   <= w_present_next && !r_present;
            if (r_fresh) begin
                r_hold <= w_byte;
            end
            if (w_start) begin
                r_is_read <= w_rd_any;
                r_len     <= w_rd_any ? w_len_sel : 8'd0;
                r_src     <= w_src_sel;
            end
            if (send_read_resp) begin
                r_pend_len <= resp_payload_len;
                r_pend_src <= resp_src_addr;
            end
            // Read responses win arbitration; the served flag clears as its frame enters HDR.
            if (w_start && w_rd_any) begin
                r_pend_rd <= 1'b0;
            end else if (send_read_resp) begin
                r_pend_rd <= 1'b1;
            end
            if (w_start && !w_rd_any) begin
                r_pend_wr <= 1'b0;
            end else if (send_write_resp) begin
                r_pend_wr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ecpri_tx.sv
// Bench for ecpri_tx: random memory image, directed and random requests, frames compared to a byte-list model.
module tb_ecpri_tx;
    localparam int          HL = 42;
    localparam logic [15:0] HB = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        send_write_resp = 1'b0;
    logic        send_read_resp = 1'b0;
    logic [7:0]  resp_payload_len = 8'd0;
    logic [15:0] resp_src_addr = 16'd0;
    logic [15:0] addr_3;
    logic        oe_3;
    logic [7:0]  data_3;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_sop, tx_eop, busy;

    logic [7:0]  mem [0:65535];
    int          vectors = 0;
    int          miscompares = 0;

    typedef logic [7:0] bq_t[$];

    ecpri_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .HDR_BASE(HB), .HDR_LEN(HL)) dut (
        .clk(clk), .reset(reset),
        .send_write_resp(send_write_resp), .send_read_resp(send_read_resp),
        .resp_payload_len(resp_payload_len), .resp_src_addr(resp_src_addr),
        .addr_3(addr_3), .oe_3(oe_3), .data_3(data_3),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy)
    );

    always #5 clk = ~clk;

    // Packet memory with one-cycle registered read.
    always @(posedge clk) begin
        if (oe_3) data_3 <= mem[addr_3];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame as a plain byte list built from the frame layout rules.
    function automatic bq_t build_frame(input bit is_read, input int n, input logic [15:0] src);
        bq_t q;
        int  size;
        size = is_read ? n + 1 : 1;
        for (int i = 0; i < HL; i++) q.push_back(mem[16'(HB + 16'(i))]);
        q.push_back(8'h10);
        q.push_back(is_read ? 8'h01 : 8'h11);
        q.push_back(8'(size >> 8));
        q.push_back(8'(size));
        q.push_back(8'h00);
        if (is_read) for (int j = 0; j < n; j++) q.push_back(mem[16'(src + 16'(j))]);
`ifdef ECPRI_TX_PAD_EN
        while (q.size() < 60) q.push_back(8'h00);
`endif
        return q;
    endfunction

    task automatic request(input bit wr, input bit rd, input int n, input logic [15:0] src);
        send_write_resp  = wr;
        send_read_resp   = rd;
        resp_payload_len = 8'(n);
        resp_src_addr    = src;
        tick();
        send_write_resp  = 1'b0;
        send_read_resp   = 1'b0;
        resp_payload_len = 8'($urandom);
        resp_src_addr    = 16'($urandom);
        chk("first_load", 64'({oe_3, addr_3, busy, tx_valid}), 64'({1'b1, HB, 1'b1, 1'b0}));
        tick();
        chk("first_present", 64'({tx_valid, tx_sop}), 64'(2'b11));
    endtask

    // mode 0: ready always; 1: ready one cycle in three; 2: random. stop_at >= 0 returns early at that byte.
    task automatic run_frame(input bq_t exp, input int mode, input int stop_at);
        int         idx = 0;
        int         cyc = 0;
        int         budget;
        logic       stalled = 1'b0;
        logic [10:0] held = '0;
        budget = 8 * exp.size() + 64;
        while (idx < exp.size() && idx != stop_at && cyc < budget) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 2);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) chk("stall_hold", 64'({tx_valid, tx_data, tx_sop, tx_eop}), 64'(held));
            if (tx_valid && tx_ready) begin
                chk($sformatf("byte%0d", idx), 64'({tx_data, tx_sop, tx_eop, busy}),
                    64'({exp[idx], 1'(idx == 0), 1'(idx == exp.size() - 1), 1'b1}));
                idx++;
            end
            stalled = tx_valid && !tx_ready;
            held    = {tx_valid, tx_data, tx_sop, tx_eop};
            tick();
            cyc++;
        end
        if (cyc >= budget) chk("frame_timeout", 64'(idx), 64'(exp.size()));
    endtask

    initial begin
        bq_t         f, f2;
        bit          rd;
        int          n;
        logic [15:0] src;

        tx_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < HL; i++) mem[16'(HB + 16'(i))] = 8'(i);
        mem[16'h0100] = 8'hAA; mem[16'h0101] = 8'hBB;
        mem[16'h0102] = 8'hCC; mem[16'h0103] = 8'hDD;

        reset = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 64'({tx_data, tx_valid, tx_sop, tx_eop, oe_3, addr_3, busy}), 64'(0));
        reset = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));

        // Write response, ready held high.
        f = build_frame(1'b0, 0, 16'h0);
        request(1'b1, 1'b0, 0, 16'h0);
        run_frame(f, 0, -1);
        chk("wr_end", 64'({tx_valid, busy}), 64'(2'b00));

        // Read response N=4 from 0x0100.
        f = build_frame(1'b1, 4, 16'h0100);
        request(1'b0, 1'b1, 4, 16'h0100);
        run_frame(f, 0, -1);
        chk("rd4_end", 64'({tx_valid, busy}), 64'(2'b00));

        // Simultaneous write and read (N=0): read first, write immediately after.
        f  = build_frame(1'b1, 0, 16'h0100);
        f2 = build_frame(1'b0, 0, 16'h0);
        request(1'b1, 1'b1, 0, 16'h0100);
        run_frame(f, 0, -1);
        chk("b2b_next_load", 64'({tx_valid, busy, oe_3, addr_3}), 64'({1'b0, 1'b1, 1'b1, HB}));
        tick();
        run_frame(f2, 0, -1);
        chk("b2b_end", 64'({tx_valid, busy}), 64'(2'b00));

        // Read N=16 with ready one cycle in three.
        src = 16'($urandom);
        f = build_frame(1'b1, 16, src);
        request(1'b0, 1'b1, 16, src);
        run_frame(f, 1, -1);
        chk("rd16_end", 64'({tx_valid, busy}), 64'(2'b00));

        // Abort at byte 20 with a write request pending; reset must drop everything.
        src = 16'($urandom);
        f = build_frame(1'b1, 30, src);
        request(1'b0, 1'b1, 30, src);
        run_frame(f, 0, 20);
        send_write_resp = 1'b1;
        tick();
        send_write_resp = 1'b0;
        reset = 1'b0;
        tick();
        chk("abort_outputs", 64'({tx_data, tx_valid, tx_sop, tx_eop, oe_3, addr_3, busy}), 64'(0));
        reset = 1'b1;
        tick();
        chk("abort_idle", 64'({tx_valid, busy}), 64'(2'b00));
        f = build_frame(1'b0, 0, 16'h0);
        request(1'b1, 1'b0, 0, 16'h0);
        run_frame(f, 0, -1);
        chk("post_abort_end", 64'({tx_valid, busy}), 64'(2'b00));

        // Read N=20 (unpadded in either build) and N=255 wrapping the address space.
        src = 16'($urandom);
        f = build_frame(1'b1, 20, src);
        request(1'b0, 1'b1, 20, src);
        run_frame(f, 2, -1);
        chk("rd20_end", 64'({tx_valid, busy}), 64'(2'b00));
        f = build_frame(1'b1, 255, 16'hFFF0);
        request(1'b0, 1'b1, 255, 16'hFFF0);
        run_frame(f, 0, -1);
        chk("rd255_end", 64'({tx_valid, busy}), 64'(2'b00));

        // Random frames with random backpressure.
        for (int k = 0; k < 6; k++) begin
            rd  = 1'($urandom_range(0, 1));
            n   = $urandom_range(0, 40);
            src = 16'($urandom);
            f = build_frame(rd, rd ? n : 0, src);
            request(!rd, rd, n, src);
            run_frame(f, 2, -1);
            chk($sformatf("rand%0d_end", k), 64'({tx_valid, busy}), 64'(2'b00));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
